// File: rtl/prec_pkg.sv
// Shared types and float-ordering helpers for the arg-min datapath.
// prec_lt compares IEEE sign-magnitude values; -0 and +0 compare equal.
package prec_pkg;

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

    // Storage width of each supported float format.
    function automatic int prec_width(input string p);
        if (p == "DOUBLE") return 64;
        if (p == "SINGLE") return 32;
        return 16;
    endfunction

    // Pipeline depth of a min_index_vector over n elements.
    function automatic int tree_latency(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Strict a < b for values zero-extended to 64 bits.
    function automatic logic prec_lt(input logic [63:0] a,
                                     input logic [63:0] b,
                                     input string p);
        int          w;
        logic [63:0] mask;
        logic [63:0] ma;
        logic [63:0] mb;
        logic        sa;
        logic        sb;
        w    = prec_width(p);
        mask = (64'd1 << (w - 1)) - 64'd1;
        ma   = a & mask;
        mb   = b & mask;
        sa   = a[6'(w - 1)];
        sb   = b[6'(w - 1)];
        if (ma == 64'd0 && mb == 64'd0) return 1'b0;
        if (sa != sb) return sa;
        return sa ? (ma > mb) : (ma < mb);
    endfunction

endpackage

// File: rtl/min_index_vector.sv
// Arg-min over N elements with a fixed pipeline latency.
// Ties resolve to the lowest index.
module min_index_vector
    import prec_pkg::*;
#(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    N         = 4,
    parameter int    IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [BITS-1:0] x [N],
    output logic            out_valid,
    output logic [IW-1:0]   index,
    output logic [BITS-1:0] c
);

    localparam int L = tree_latency(N);

    logic [IW-1:0]   best_i;
    logic [BITS-1:0] best_c;
    logic            v_q [L];
    logic [IW-1:0]   i_q [L];
    logic [BITS-1:0] c_q [L];

    // Linear scan; strict less-than keeps the earlier index on ties.
    always_comb begin
        best_i = '0;
        best_c = x[0];
        for (int i = 1; i < N; i++) begin
            if (prec_lt(64'(x[i]), 64'(best_c), PRECISION)) begin
                best_i = IW'(i);
                best_c = x[i];
            end
        end
    end

    // Delay line that sets the fixed result latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < L; s++) v_q[s] <= 1'b0;
        end else begin
            v_q[0] <= in_valid;
            i_q[0] <= best_i;
            c_q[0] <= best_c;
            for (int s = 1; s < L; s++) begin
                v_q[s] <= v_q[s-1];
                i_q[s] <= i_q[s-1];
                c_q[s] <= c_q[s-1];
            end
        end
    end

    assign out_valid = v_q[L-1];
    assign index     = i_q[L-1];
    assign c         = c_q[L-1];

endmodule

// File: rtl/argmin_chunk_sequencer.sv
// Streams a long vector chunk by chunk through one arg-min tree
// and folds the per-chunk results into a global arg-min.
module argmin_chunk_sequencer
    import prec_pkg::*;
#(
    parameter int    BITS       = 16,
    parameter string PRECISION  = "HALF",
    parameter int    CHUNK      = 4,
    parameter int    NUM_CHUNKS = 8,
    parameter int    INDEX_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       chunk [CHUNK],
    output logic                  busy,
    output logic                  out_valid,
    output logic [INDEX_BITS-1:0] index,
    output logic [BITS-1:0]       c
);

    localparam int L  = tree_latency(CHUNK);
    localparam int CW = $clog2(NUM_CHUNKS + 1);
    localparam int FW = $clog2(L + 1);
    localparam int LW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    if (CHUNK < 1) begin : g_bad_chunk
        $error("CHUNK must be >= 1");
    end
    if (NUM_CHUNKS < 1) begin : g_bad_num
        $error("NUM_CHUNKS must be >= 1");
    end
    if (INDEX_BITS < $clog2(CHUNK * NUM_CHUNKS)) begin : g_bad_idx
        $error("INDEX_BITS too small");
    end

    state_e                state;
    logic [CW-1:0]         issue_cnt;
    logic [CW-1:0]         ret_cnt;
    logic [FW-1:0]         flush_cnt;
    logic [INDEX_BITS-1:0] run_idx;
    logic [BITS-1:0]       run_c;

    logic                  t_valid;
    logic [LW-1:0]         t_idx;
    logic [BITS-1:0]       t_c;

    logic                  accept;
    logic                  res_v;
    logic                  take;
    logic [INDEX_BITS-1:0] g_idx;
    logic [INDEX_BITS-1:0] new_idx;
    logic [BITS-1:0]       new_c;

    min_index_vector #(
        .BITS      (BITS),
        .PRECISION (PRECISION),
        .N         (CHUNK),
        .IW        (LW)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .x         (chunk),
        .out_valid (t_valid),
        .index     (t_idx),
        .c         (t_c)
    );

    // Results are combined only inside a job and once aborted work has drained.
    always_comb begin
        accept  = in_valid && in_ready;
        res_v   = t_valid && (flush_cnt == '0)
                  && (state == FEED || state == DRAIN);
        g_idx   = INDEX_BITS'(ret_cnt) * INDEX_BITS'(CHUNK)
                  + INDEX_BITS'(t_idx);
        take    = (ret_cnt == '0)
                  || prec_lt(64'(t_c), 64'(run_c), PRECISION);
        new_idx = take ? g_idx : run_idx;
        new_c   = take ? t_c : run_c;
    end

    // Job sequencing, running minimum and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            index     <= '0;
            c         <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            flush_cnt <= '0;
            run_idx   <= '0;
            run_c     <= '0;
        end else if (abort) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            flush_cnt <= FW'(L);
        end else begin
            if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
            if (res_v) begin
                run_idx <= new_idx;
                run_c   <= new_c;
                ret_cnt <= ret_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && flush_cnt == '0) begin
                        state     <= FEED;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                    end
                end
                FEED: begin
                    if (accept) begin
                        if (issue_cnt == CW'(NUM_CHUNKS - 1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            issue_cnt <= issue_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (res_v && ret_cnt == CW'(NUM_CHUNKS - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        index     <= new_idx;
                        c         <= new_c;
                    end
                end
                DONE: begin
                    if (start) begin
                        state     <= FEED;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        out_valid <= 1'b0;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmin_chunk_sequencer.sv
// Directed bench for argmin_chunk_sequencer.
// Covers ordering, ties, signed zero, gaps, abort, reset and a single-chunk build.
module tb_argmin_chunk_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] chunk [4];
    logic        busy;
    logic        out_valid;
    logic [4:0]  index;
    logic [15:0] c;

    logic        s_start = 1'b0;
    logic        s_abort = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_chunk [3];
    logic        s_busy;
    logic        s_out_valid;
    logic [1:0]  s_index;
    logic [15:0] s_c;

    logic [15:0] vec [32];
    int          total = 0;
    int          bad = 0;
    int          lat;

    always #5 clk = ~clk;

    argmin_chunk_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .chunk(chunk),
        .busy(busy), .out_valid(out_valid), .index(index), .c(c)
    );

    argmin_chunk_sequencer #(
        .BITS(16), .PRECISION("HALF"), .CHUNK(3),
        .NUM_CHUNKS(1), .INDEX_BITS(2)
    ) dut1 (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .in_valid(s_valid), .in_ready(s_ready), .chunk(s_chunk),
        .busy(s_busy), .out_valid(s_out_valid), .index(s_index), .c(s_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] h(input int n);
        int e;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return 16'(((e + 15) << 10) | ((n - (1 << e)) << (10 - e)));
    endfunction

    task automatic set_base();
        for (int i = 0; i < 32; i++) vec[i] = h(32 - i);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ready", 32'(in_ready), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_ov", 32'(out_valid), 0);
    endtask

    task automatic beat(input int b, input int gap, input bit poke);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start = poke && (g == 0);
            chk("gap_busy", 32'(busy), 1);
        end
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        for (int e = 0; e < 4; e++) chunk[e] = vec[b*4 + e];
        @(posedge clk);
    endtask

    task automatic wait_done(output int n);
        n = 99;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic job(input string tag, input int gmax, input bit poke,
                       input logic [4:0] ei, input logic [15:0] ec);
        do_start();
        for (int b = 0; b < 8; b++)
            beat(b, (gmax > 0) ? $urandom_range(gmax, 0) : 0, poke);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), LAT + 1);
        chk({tag, "_idx"}, 32'(index), 32'(ei));
        chk({tag, "_c"}, 32'(c), 32'(ec));
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        for (int e = 0; e < 4; e++) chunk[e] = '0;
        for (int e = 0; e < 3; e++) s_chunk[e] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_idx", 32'(index), 0);
        chk("rst_c", 32'(c), 0);

        set_base();
        vec[21] = 16'h3800;
        job("half", 0, 1'b0, 5'd21, 16'h3800);

        set_base();
        vec[5]  = 16'h0000;
        vec[26] = 16'h0000;
        job("tie", 0, 1'b0, 5'd5, 16'h0000);

        vec[26] = 16'h8000;
        job("negz", 0, 1'b0, 5'd5, 16'h0000);

        set_base();
        vec[3]  = 16'hBC00;
        vec[30] = 16'hC000;
        job("neg", 0, 1'b0, 5'd30, 16'hC000);

        set_base();
        vec[21] = 16'h3800;
        job("gaps", 3, 1'b1, 5'd21, 16'h3800);

        set_base();
        vec[3] = 16'hBC00;
        do_start();
        for (int b = 0; b < 5; b++) beat(b, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", 32'(in_ready), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ov", 32'(out_valid), 0);
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("abort_quiet", 32'(out_valid), 0);
        end
        set_base();
        vec[0] = 16'h3400;
        job("postabort", 0, 1'b0, 5'd0, 16'h3400);

        set_base();
        vec[9] = 16'h3000;
        do_start();
        for (int b = 0; b < 8; b++) beat(b, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("drst_ready", 32'(in_ready), 0);
        chk("drst_busy", 32'(busy), 0);
        chk("drst_ov", 32'(out_valid), 0);
        chk("drst_idx", 32'(index), 0);
        chk("drst_c", 32'(c), 0);
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("drst_quiet", 32'(out_valid), 0);
        end
        set_base();
        vec[21] = 16'h3800;
        job("postrst", 0, 1'b0, 5'd21, 16'h3800);

        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("one_ready", 32'(s_ready), 1);
        s_valid = 1'b1;
        s_chunk[0] = 16'h4000;
        s_chunk[1] = 16'h3C00;
        s_chunk[2] = 16'h3800;
        @(posedge clk);
        lat = 99;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            s_valid = 1'b0;
            if (k == 1) chk("one_drain", 32'(s_ready), 0);
            if (s_out_valid) begin
                lat = k;
                break;
            end
        end
        chk("one_lat", 32'(lat), LAT + 1);
        chk("one_idx", 32'(s_index), 2);
        chk("one_c", 32'(s_c), 32'h3800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
